// File: rtl/fp32_pkg.sv
// Shared IEEE-754 single-precision definitions for the float-to-int converter.
package fp32_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  localparam logic [EXP_W-1:0] BIAS    = 8'd127;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  // Exponent at which the hidden-bit mantissa is already an integer (e = 23).
  localparam logic [EXP_W-1:0] EXP_ALIGN = 8'(BIAS + FRAC_W);
  // First exponent whose magnitude no longer fits a signed 32-bit result (e = 31).
  localparam logic [EXP_W-1:0] EXP_SAT   = 8'(BIAS + 31);

  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Saturated result chosen by the sign of an out-of-range operand.
  function automatic logic [31:0] saturate(input logic sign);
    return sign ? INT_MIN : INT_MAX;
  endfunction

endpackage

// File: rtl/fp32_classify.sv
// Unpacks a single-precision word into its fields and special-value classes.
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [31:0]       data,
  output logic              sign,
  output logic [EXP_W-1:0]  exp,
  output logic [FRAC_W-1:0] frac,
  output logic              is_nan,
  output logic              is_inf,
  output logic              is_zero,
  output logic              is_denorm
);

  // Pure field split plus class decode; no state.
  always_comb begin
    sign      = data[31];
    exp       = data[30:23];
    frac      = data[22:0];
    is_nan    = (exp == EXP_MAX) && (frac != '0);
    is_inf    = (exp == EXP_MAX) && (frac == '0);
    is_zero   = (exp == '0) && (frac == '0);
    is_denorm = (exp == '0) && (frac != '0);
  end

endmodule

// File: rtl/float_to_int_seq.sv
// Sequential float-to-int converter, round toward zero, one shift per cycle.
module float_to_int_seq
  import fp32_pkg::*;
#(
  parameter logic [31:0] NAN_RESULT = 32'h7FFF_FFFF
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_flags
);

  logic              sign;
  logic [EXP_W-1:0]  exp;
  logic [FRAC_W-1:0] frac;
  logic              is_nan;
  logic              is_inf;
  logic              is_zero;
  logic              is_denorm;

  fp32_classify u_classify (
    .data      (in_data),
    .sign      (sign),
    .exp       (exp),
    .frac      (frac),
    .is_nan    (is_nan),
    .is_inf    (is_inf),
    .is_zero   (is_zero),
    .is_denorm (is_denorm)
  );

  state_t      state;
  logic [31:0] mag;
  logic [4:0]  count;
  logic        dir_left;
  logic        sticky;
  logic        neg;

  logic        is_tiny;
  logic        is_huge;
  logic        is_min_exact;
  logic        shift_left;
  logic [4:0]  shift_amt;

  assign in_ready = (state == IDLE);

  // Operand classification and shift setup, meaningful only on the accept cycle.
  always_comb begin
    is_tiny      = is_denorm || ((exp != '0) && (exp < BIAS));
    is_huge      = (exp >= EXP_SAT);
    is_min_exact = sign && (exp == EXP_SAT) && (frac == '0);
    shift_left   = (exp > EXP_ALIGN);
    shift_amt    = shift_left ? 5'(exp - EXP_ALIGN) : 5'(EXP_ALIGN - exp);
  end

  // Control FSM and datapath: specials resolve at accept, normals shift then finish.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      sticky    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
      mag       <= '0;
      dir_left  <= 1'b0;
      neg       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_nan) begin
              out_data  <= NAN_RESULT;
              out_flags <= 3'b100;
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (is_inf) begin
              out_data  <= saturate(sign);
              out_flags <= 3'b010;
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (is_zero) begin
              out_data  <= '0;
              out_flags <= 3'b000;
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (is_tiny) begin
              out_data  <= '0;
              out_flags <= 3'b001;
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (is_huge) begin
              out_data  <= is_min_exact ? INT_MIN : saturate(sign);
              out_flags <= is_min_exact ? 3'b000 : 3'b010;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              mag      <= {8'b0, 1'b1, frac};
              count    <= shift_amt;
              dir_left <= shift_left;
              neg      <= sign;
              sticky   <= 1'b0;
              state    <= (shift_amt != '0) ? SHIFT : FINISH;
            end
          end
        end
        SHIFT: begin
          if (dir_left) begin
            mag <= mag << 1;
          end else begin
            mag <= mag >> 1;
            if (mag[0]) begin
              sticky <= 1'b1;
            end
          end
          count <= count - 5'd1;
          if (count == 5'd1) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          out_data  <= neg ? -mag : mag;
          out_flags <= {2'b00, sticky};
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_int_seq.sv
// Directed self-checking bench for float_to_int_seq with hand-computed results.
module tb_float_to_int_seq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_flags;

  int assertCount;
  int failCount;

  float_to_int_seq #(.NAN_RESULT(32'h7FFF_FFFF)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Sends one operand, measures accept-to-out_valid latency, checks result, drains it.
  task automatic applyStimulus(input string tag, input logic [31:0] operand,
                               input logic [31:0] expData, input logic [2:0] expFlags,
                               input int expLat);
    int lat;
    @(negedge clk);
    checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_data  = operand;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, " data"}, out_data, expData);
    checkOutput({tag, " flags"}, 32'(out_flags), 32'(expFlags));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, " drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int rises;
    logic prevValid;

    assertCount = 0;
    failCount   = 0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_data", out_data, 32'd0);
    checkOutput("reset out_flags", 32'(out_flags), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);

    applyStimulus("one",       32'h3F80_0000, 32'h0000_0001, 3'b000, 25);
    applyStimulus("neg2p5",    32'hC020_0000, 32'hFFFF_FFFE, 3'b001, 24);
    applyStimulus("two24",     32'h4B80_0000, 32'h0100_0000, 3'b000, 3);
    applyStimulus("two23",     32'h4B00_0000, 32'h0080_0000, 3'b000, 2);
    applyStimulus("negalign",  32'hCB00_0001, 32'hFF7F_FFFF, 3'b000, 2);
    applyStimulus("maxfinite", 32'h4EFF_FFFF, 32'h7FFF_FF80, 3'b000, 9);
    applyStimulus("onehalf",   32'h3FC0_0000, 32'h0000_0001, 3'b001, 25);
    applyStimulus("sat_pos",   32'h4F00_0000, 32'h7FFF_FFFF, 3'b010, 1);
    applyStimulus("min_exact", 32'hCF00_0000, 32'h8000_0000, 3'b000, 1);
    applyStimulus("neg_inf",   32'hFF80_0000, 32'h8000_0000, 3'b010, 1);
    applyStimulus("pos_inf",   32'h7F80_0000, 32'h7FFF_FFFF, 3'b010, 1);
    applyStimulus("nan",       32'h7FC0_0000, 32'h7FFF_FFFF, 3'b100, 1);
    applyStimulus("denorm",    32'h0000_0001, 32'h0000_0000, 3'b001, 1);
    applyStimulus("neg_zero",  32'h8000_0000, 32'h0000_0000, 3'b000, 1);
    applyStimulus("below_one", 32'h3F7F_FFFF, 32'h0000_0000, 3'b001, 1);

    // Backpressure: hold the result of 3.0 while offering another operand.
    @(negedge clk);
    in_data  = 32'h4040_0000;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("bp latency", 32'(lat), 32'd24);
    in_data  = 32'h3F80_0000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp data stable", out_data, 32'h0000_0003);
      checkOutput("bp in_ready low", 32'(in_ready), 32'd0);
      checkOutput("bp valid held", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("bp drained", 32'(out_valid), 32'd0);
    checkOutput("bp in_ready back", 32'(in_ready), 32'd1);
    rises = 0;
    prevValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid && !prevValid) rises++;
      prevValid = out_valid;
    end
    checkOutput("bp single result", 32'(rises), 32'd0);

    // Reset in the middle of shifting 1.0 must drop the operation.
    @(negedge clk);
    in_data  = 32'h3F80_0000;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("rst mid in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("rst in_ready", 32'(in_ready), 32'd1);
    rises = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) rises++;
    end
    checkOutput("rst no output", 32'(rises), 32'd0);

    applyStimulus("post_rst", 32'h3F80_0000, 32'h0000_0001, 3'b000, 25);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/float_to_int_seq.md
FLOAT_TO_INT_SEQ -- requirements
Module: float_to_int_seq

Interface
REQ-001 The block SHALL have parameter NAN_RESULT, default 32'h7FFF_FFFF, which is the integer returned for a NaN input.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the in_data operand is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand this cycle.
REQ-006 The block SHALL have port in_data, input, 32 bits: IEEE-754 single {sign, exp[7:0], frac[22:0]}.
REQ-007 The block SHALL have port out_valid, output, 1 bit: out_data and out_flags are valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-009 The block SHALL have port out_data, output, 32 bits: the two's-complement signed integer result.
REQ-010 The block SHALL have port out_flags, output, 3 bits: {invalid, overflow, inexact}.

Function
REQ-011 Conversion SHALL round toward zero; the unbiased exponent e is exp-127.
REQ-012 A transfer SHALL occur only on a cycle where valid and ready are both high; in_ready SHALL be high only in state IDLE.
REQ-013 The FSM states SHALL be IDLE, SHIFT, FINISH and DONE.
REQ-014 On accept with a normal operand and 0<=e<=30, the block SHALL load mantissa {1,frac}, set count=|e-23| and dir=left if e>23; it SHALL go to SHIFT if count>0, else to FINISH.
REQ-015 SHIFT SHALL shift the mantissa one bit per cycle and decrement count; when count reaches 1 the next state SHALL be FINISH.
REQ-016 On right shifts, any 1 bit shifted out SHALL set a sticky inexact flag.
REQ-017 FINISH SHALL negate the magnitude if sign=1, register out_data and out_flags, and go to DONE.
REQ-018 For normal operands, out_valid SHALL rise exactly count+2 cycles after the accept cycle.
REQ-019 Special operands SHALL go directly from IDLE to DONE, with out_valid high on the cycle after accept.
REQ-020 For a NaN input (exp=255, frac!=0), the result SHALL be NAN_RESULT with flags 3'b100.
REQ-021 For +inf the result SHALL be 0x7FFFFFFF, and for -inf 0x80000000, with flags 3'b010.
REQ-022 For finite inputs with e>=31, the result SHALL saturate by sign with flags 3'b010; the sole exception is 0xCF000000, which SHALL give 0x80000000 with flags 3'b000.
REQ-023 For exp=0 and frac=0 (±0), the result SHALL be 0 with flags 0.
REQ-024 For any other input with e<0, denormals included, the result SHALL be 0 with flags 3'b001.
REQ-025 In DONE, out_data and out_flags SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 In DONE with out_ready=1, the next state SHALL be IDLE, so the next accept is possible one cycle later.
REQ-027 in_valid asserted in any state other than IDLE SHALL be ignored, with no transfer.

Reset
REQ-028 While reset=1, the next state SHALL be IDLE, count 0, sticky 0, out_valid 0, out_data 0 and out_flags 0, so in_ready=1 on the first cycle after reset.
REQ-029 Reset asserted in SHIFT, FINISH or DONE SHALL discard the in-flight operation without emitting a result.

Structure
REQ-030 The shared package fp32_pkg SHALL hold the field widths (EXP_W=8, FRAC_W=23), BIAS=127, EXP_MAX=8'hFF, INT_MAX/INT_MIN and the state enum.
REQ-031 Combinational unpacking SHALL be done in sub-module fp32_classify, with outputs sign, exp, frac, is_nan, is_inf, is_zero and is_denorm.
REQ-032 Magnitude datapath width SHALL be 32 bits; count SHALL be 5 bits.

Verification
REQ-033 The bench SHALL cover: 0x3F800000 (1.0) -> out_data 0x00000001, flags 000, out_valid 25 cycles after accept.
REQ-034 The bench SHALL cover: 0xC0200000 (-2.5) -> 0xFFFFFFFE, flags 001; and 0x4B800000 -> 0x01000000, flags 000, out_valid 3 cycles after accept.
REQ-035 The bench SHALL cover: 0x4F000000 -> 0x7FFFFFFF, flags 010; 0xCF000000 -> 0x80000000, flags 000; 0xFF800000 -> 0x80000000, flags 010.
REQ-036 The bench SHALL cover: 0x7FC00000 -> NAN_RESULT, flags 100, out_valid 1 cycle after accept; and 0x00000001 -> 0, flags 001.
REQ-037 The bench SHALL cover backpressure: out_ready held low 5 cycles in DONE -> out_data stable, in_ready low, and a single result delivered.
REQ-038 The bench SHALL cover reset during SHIFT of 1.0 -> out_valid never rises, and in_ready=1 on the cycle after reset deasserts.
